// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: credit-limited sequential prefetch into an in-order
// queue, with branch-redirect flush that drops responses to in-flight stale requests.
module fetch_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_W-1:0]            imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [DATA_W-1:0]            imem_resp_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err_resp
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [DATA_W-1:0] instrMem [DEPTH];
    logic [ADDR_W-1:0] pcMem    [DEPTH];

    logic [PTR_W-1:0]  headPtr, tailPtr;
    logic [OCC_W-1:0]  count;
    logic [OUT_W-1:0]  outstanding, stale, outstandingNext;
    logic [ADDR_W-1:0] fetchPc, respPc;
    logic              errResp;

    logic              reqFire, respLive, respSpurious, pushEn, popEn;
    logic [31:0]       creditUsed;

    // Stale requests already own no queue slot, so they are excluded from the credit.
    always_comb begin
        creditUsed      = 32'(count) + 32'(outstanding) - 32'(stale);
        imem_req_valid  = !reset && !redirect_valid
                          && (32'(outstanding) < 32'(MAX_OUT))
                          && (creditUsed < 32'(DEPTH));
        reqFire         = imem_req_valid && imem_req_ready;
        respLive        = imem_resp_valid && (outstanding != '0);
        respSpurious    = imem_resp_valid && (outstanding == '0);
        pushEn          = respLive && (stale == '0) && !redirect_valid;
        out_valid       = (count != '0) && !redirect_valid;
        popEn           = out_valid && out_ready;
        outstandingNext = outstanding + OUT_W'(reqFire) - OUT_W'(respLive);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            headPtr     <= '0;
            tailPtr     <= '0;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            errResp     <= 1'b0;
        end else begin
            outstanding <= outstandingNext;
            if (respSpurious)
                errResp <= 1'b1;
            if (redirect_valid) begin
                fetchPc <= redirect_pc;
                respPc  <= redirect_pc;
                headPtr <= '0;
                tailPtr <= '0;
                count   <= '0;
                stale   <= outstandingNext;
            end else begin
                if (reqFire)
                    fetchPc <= fetchPc + PC_STEP;
                if (respLive && (stale != '0))
                    stale <= stale - OUT_W'(1);
                if (pushEn) begin
                    respPc  <= respPc + PC_STEP;
                    tailPtr <= tailPtr + PTR_W'(1);
                end
                if (popEn)
                    headPtr <= headPtr + PTR_W'(1);
                count <= count + OCC_W'(pushEn) - OCC_W'(popEn);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            instrMem[tailPtr] <= imem_resp_data;
            pcMem[tailPtr]    <= respPc + PC_STEP;
        end
    end

    always_comb begin
        imem_req_addr = fetchPc;
        occupancy     = count;
        err_resp      = errResp;
        out_instr     = (count != '0) ? instrMem[headPtr] : '0;
        out_pc_plus4  = (count != '0) ? pcMem[headPtr]    : '0;
    end

endmodule
